// File: rtl/adder_8bit_seq_arb_if.sv
// Request/response bundle for the byte-serial shared adder: two requesters and one response port.
interface adder_8bit_seq_arb_if #(
  parameter int unsigned BYTES = 4
);
  localparam int unsigned W = 8 * BYTES;

  logic         req0_valid;
  logic         req0_ready;
  logic [W-1:0] req0_a;
  logic [W-1:0] req0_b;
  logic         req0_sub;

  logic         req1_valid;
  logic         req1_ready;
  logic [W-1:0] req1_a;
  logic [W-1:0] req1_b;
  logic         req1_sub;

  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_sum;
  logic         rsp_cout;
  logic         rsp_id;

  // Client side: issues operations and consumes results.
  modport master (
    output req0_valid, req0_a, req0_b, req0_sub,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_sub,
    input  req1_ready,
    input  rsp_valid, rsp_sum, rsp_cout, rsp_id,
    output rsp_ready
  );

  // Controller side: accepts operations and produces results.
  modport slave (
    input  req0_valid, req0_a, req0_b, req0_sub,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_sub,
    output req1_ready,
    output rsp_valid, rsp_sum, rsp_cout, rsp_id,
    input  rsp_ready
  );
endinterface

// File: rtl/adder_8bit_seq_arb.sv
// Byte-serial wide add/subtract through one shared 8-bit ripple adder, round-robin between two requesters.

module adder_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);
  logic c;

  // Ripple the carry bit by bit through the byte.
  always_comb begin
    c   = cin;
    sum = 8'd0;
    for (int i = 0; i < 8; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end
endmodule

module adder_8bit_seq_arb #(
  parameter int unsigned BYTES = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  adder_8bit_seq_arb_if.slave bus
);
  localparam int unsigned W  = 8 * BYTES;
  localparam int unsigned KW = (BYTES > 1) ? $clog2(BYTES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          next_state;
  logic            rr;
  logic            id;
  logic            carry;
  logic [KW-1:0]   k;
  logic [W-1:0]    op_a;
  logic [W-1:0]    op_b;
  logic [W-1:0]    sum_q;
  logic            cout_q;
  logic            id_q;
  logic            valid_q;

  logic            grant0_c;
  logic            grant1_c;
  logic            accept_c;
  logic            last_c;
  logic [KW+2:0]   byte_off_c;
  logic [7:0]      add_sum_c;
  logic            add_cout_c;
  logic [W-1:0]    sel_a_c;
  logic [W-1:0]    sel_b_c;
  logic            sel_sub_c;

  // Round-robin grant: rr names the requester favoured when both are valid.
  always_comb begin
    grant0_c = bus.req0_valid & (~bus.req1_valid | ~rr);
    grant1_c = bus.req1_valid & (~bus.req0_valid | rr);
  end

  assign bus.req0_ready = (state == IDLE) & rst_n & grant0_c;
  assign bus.req1_ready = (state == IDLE) & rst_n & grant1_c;
  assign accept_c       = bus.req0_ready | bus.req1_ready;

  // Operand mux for the granted requester.
  always_comb begin
    sel_a_c   = bus.req1_ready ? bus.req1_a   : bus.req0_a;
    sel_b_c   = bus.req1_ready ? bus.req1_b   : bus.req0_b;
    sel_sub_c = bus.req1_ready ? bus.req1_sub : bus.req0_sub;
  end

  assign byte_off_c = {k, 3'b000};
  assign last_c     = (k == KW'(BYTES - 1));

  adder_8bit u_adder (
    .a    (op_a[byte_off_c +: 8]),
    .b    (op_b[byte_off_c +: 8]),
    .cin  (carry),
    .sum  (add_sum_c),
    .cout (add_cout_c)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept_c)      next_state = CALC;
      CALC:    if (last_c)        next_state = DONE;
      DONE:    if (bus.rsp_ready) next_state = IDLE;
      default:                    next_state = IDLE;
    endcase
  end

  // Operand capture, per-byte accumulation and response registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr      <= 1'b0;
      id      <= 1'b0;
      carry   <= 1'b0;
      k       <= '0;
      op_a    <= '0;
      op_b    <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      id_q    <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept_c) begin
            id    <= bus.req1_ready;
            rr    <= ~bus.req1_ready;
            op_a  <= sel_a_c;
            op_b  <= sel_sub_c ? ~sel_b_c : sel_b_c;
            carry <= sel_sub_c;
            k     <= '0;
          end
        end
        CALC: begin
          sum_q[byte_off_c +: 8] <= add_sum_c;
          carry                  <= add_cout_c;
          k                      <= k + KW'(1);
          if (last_c) begin
            cout_q  <= add_cout_c;
            id_q    <= id;
            valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (bus.rsp_ready) valid_q <= 1'b0;
        end
        default: valid_q <= 1'b0;
      endcase
    end
  end

  assign bus.rsp_valid = valid_q;
  assign bus.rsp_sum   = sum_q;
  assign bus.rsp_cout  = cout_q;
  assign bus.rsp_id    = id_q;
endmodule
